// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for the MIPS32 datapath: sequences fetch/decode/execute/
// memory/writeback, drives datapath strobes, and waits on mem_ready for memory accesses.
module mc_main_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic [ST_W-1:0] state,
    output logic            illegal_op
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 0,
        S_DECODE = 1,
        S_MEMADR = 2,
        S_MEMRD  = 3,
        S_MEMWB  = 4,
        S_MEMWR  = 5,
        S_EXEC   = 6,
        S_RWB    = 7,
        S_BEQ    = 8,
        S_JUMP   = 9,
        S_ADDIEX = 10,
        S_ADDIWB = 11,
        S_JR     = 12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (st_q)
                S_FETCH:  if (mem_ready) st_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: st_q <= S_MEMADR;
                        OP_RTYPE:     st_q <= (funct == FN_JR) ? S_JR : S_EXEC;
                        OP_BEQ:       st_q <= S_BEQ;
                        OP_J:         st_q <= S_JUMP;
                        OP_ADDI:      st_q <= S_ADDIEX;
                        default: begin
                            st_q       <= S_FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: st_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) st_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) st_q <= S_FETCH;
                S_EXEC:   st_q <= S_RWB;
                S_ADDIEX: st_q <= S_ADDIWB;
                default:  st_q <= S_FETCH;
            endcase
        end
    end

    // Strobes decode from the current state; reset gates them low immediately so an
    // interrupted access or write is dropped without waiting for a clock edge.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (rst_n) begin
            case (st_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: RegWrite = 1'b1;
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: each stimulus cycle queues its hand-derived
// expected state/strobes; a negedge monitor pops and compares.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal_op;

    mc_main_ctrl #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    localparam logic [15:0] C_ZERO = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_FW   = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
    localparam logic [15:0] C_FR   = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
    localparam logic [15:0] C_DEC  = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [15:0] C_MADR = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [15:0] C_MRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_MWB  = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [15:0] C_MWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_EXEC = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [15:0] C_RWB  = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [15:0] C_BEQ  = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [15:0] C_JMP  = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [15:0] C_AWB  = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
    localparam logic [15:0] C_JR   = 16'b1_0_0_0_0_0_0_0_0_0_00_00_11;

    typedef struct {
        string      nm;
        logic [3:0] st;
        logic [15:0] ctrl;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [15:0] act_ctrl;
    assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            if (state === e.st) n_pass++;
            else $display("FAIL %s state: got %0d expected %0d", e.nm, state, e.st);
            n_chk++;
            if (act_ctrl === e.ctrl) n_pass++;
            else $display("FAIL %s ctrl: got %b expected %b", e.nm, act_ctrl, e.ctrl);
            n_chk++;
            if (illegal_op === e.ill) n_pass++;
            else $display("FAIL %s illegal_op: got %b expected %b", e.nm, illegal_op, e.ill);
        end
    end

    task automatic step(input logic r, input logic mr, input logic [3:0] st,
                        input logic [15:0] ctrl, input logic ill, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = mr;
        e.nm = nm; e.st = st; e.ctrl = ctrl; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0; funct = 6'b0;
        step(0, 1, 0, C_ZERO, 0, "reset0");
        step(0, 1, 0, C_ZERO, 0, "reset1");

        // R-type add: 0,1,6,7
        instr(6'b000000, 6'b100000);
        step(1, 1, 0,  C_FR,   0, "rt_fetch");
        step(1, 1, 1,  C_DEC,  0, "rt_decode");
        step(1, 1, 6,  C_EXEC, 0, "rt_exec");
        step(1, 1, 7,  C_RWB,  0, "rt_rwb");

        // lw with three MEMRD wait cycles: 8 cycles total
        instr(6'b100011, 6'b000000);
        step(1, 1, 0,  C_FR,   0, "lw_fetch");
        step(1, 1, 1,  C_DEC,  0, "lw_decode");
        step(1, 1, 2,  C_MADR, 0, "lw_memadr");
        step(1, 0, 3,  C_MRD,  0, "lw_memrd_w0");
        step(1, 0, 3,  C_MRD,  0, "lw_memrd_w1");
        step(1, 0, 3,  C_MRD,  0, "lw_memrd_w2");
        step(1, 1, 3,  C_MRD,  0, "lw_memrd_rdy");
        step(1, 1, 4,  C_MWB,  0, "lw_memwb");

        // sw after two FETCH wait cycles
        instr(6'b101011, 6'b000000);
        step(1, 0, 0,  C_FW,   0, "sw_fetch_w0");
        step(1, 0, 0,  C_FW,   0, "sw_fetch_w1");
        step(1, 1, 0,  C_FR,   0, "sw_fetch_rdy");
        step(1, 1, 1,  C_DEC,  0, "sw_decode");
        step(1, 1, 2,  C_MADR, 0, "sw_memadr");
        step(1, 1, 5,  C_MWR,  0, "sw_memwr");

        instr(6'b000100, 6'b000000);
        step(1, 1, 0,  C_FR,   0, "beq_fetch");
        step(1, 1, 1,  C_DEC,  0, "beq_decode");
        step(1, 1, 8,  C_BEQ,  0, "beq_exec");

        instr(6'b000010, 6'b000000);
        step(1, 1, 0,  C_FR,   0, "j_fetch");
        step(1, 1, 1,  C_DEC,  0, "j_decode");
        step(1, 1, 9,  C_JMP,  0, "j_jump");

        instr(6'b000000, 6'b001000);
        step(1, 1, 0,  C_FR,   0, "jr_fetch");
        step(1, 1, 1,  C_DEC,  0, "jr_decode");
        step(1, 1, 12, C_JR,   0, "jr_jr");

        instr(6'b001000, 6'b000000);
        step(1, 1, 0,  C_FR,   0, "addi_fetch");
        step(1, 1, 1,  C_DEC,  0, "addi_decode");
        step(1, 1, 10, C_MADR, 0, "addi_ex");
        step(1, 1, 11, C_AWB,  0, "addi_wb");

        // Illegal opcode: pulse appears in the following FETCH for one cycle only
        instr(6'b111111, 6'b000000);
        step(1, 1, 0,  C_FR,   0, "ill_fetch");
        step(1, 1, 1,  C_DEC,  0, "ill_decode");
        step(1, 0, 0,  C_FW,   1, "ill_pulse");
        step(1, 0, 0,  C_FW,   0, "ill_clear");

        // Reset while stalled in MEMWR: strobes drop at once, no writes afterwards
        instr(6'b101011, 6'b000000);
        step(1, 1, 0,  C_FR,   0, "rsw_fetch");
        step(1, 1, 1,  C_DEC,  0, "rsw_decode");
        step(1, 1, 2,  C_MADR, 0, "rsw_memadr");
        step(1, 0, 5,  C_MWR,  0, "rsw_memwr_wait");
        step(0, 0, 0,  C_ZERO, 0, "rsw_async_reset");
        step(0, 1, 0,  C_ZERO, 0, "rsw_reset_hold");
        instr(6'b000000, 6'b100000);
        step(1, 0, 0,  C_FW,   0, "post_rst_fetch_w");
        step(1, 1, 0,  C_FR,   0, "post_rst_fetch");
        step(1, 1, 1,  C_DEC,  0, "post_rst_decode");
        step(1, 1, 6,  C_EXEC, 0, "post_rst_exec");
        step(1, 1, 7,  C_RWB,  0, "post_rst_rwb");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux/enable strobes and generates ALUOp, the 2-bit code the ALU control decoder consumes together with funct.
- Also detects JR (R-type, funct 6'b001000) and steers the PC from the register file. Waits on a memory-ready handshake for instruction and data accesses.

Parameters:
- ST_W, 4, state register width (13 states used).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26]; stable from the cycle after FETCH completes.
- funct  input  6  IR[5:0]; used only for JR detection.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero (datapath ANDs it).
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data select: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  destination select: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  output  2  00 = add, 01 = subtract (branch), 10 = decode funct.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (JR).
- state  output  ST_W  current state, for debug.
- illegal_op  output  1  registered 1-cycle pulse on an unsupported opcode.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state = FETCH (0) and illegal_op = 0.
  - While rst_n is low, all control outputs are forced to 0.
  - A reset mid-instruction abandons it: no RegWrite/MemWrite/PCWrite is issued afterwards.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, JUMP 9, ADDIEX 10, ADDIWB 11, JR 12. Encodings 13–15 return to FETCH.
- Outputs are combinational from state (plus mem_ready where noted). Every output not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
    - 100011 or 101011 -> MEMADR.
    - 000000 with funct 001000 -> JR.
    - 000000 otherwise -> EXEC.
    - 000100 -> BEQ.
    - 000010 -> JUMP.
    - 001000 -> ADDIEX.
    - Any other opcode -> FETCH, with illegal_op=1 on the next cycle.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if opcode=100011, else MEMWR.
  - MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
  - JR: PCWrite=1, PCSource=11 -> FETCH.
- Handshake rules:
  - MemRead/MemWrite stay asserted continuously while waiting.
  - The request is never withdrawn before mem_ready.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Latency with mem_ready tied high, counted as cycles from FETCH entry to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jr 3. Each wait cycle adds 1.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are never both 1 in any state.

Test Plan:
- Reset/latency: hold rst_n=0 -> all outputs 0, state=0. Release with mem_ready=1, opcode=000000, funct=100000 -> states 0,1,6,7,0. ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in RWB.
- lw: opcode=100011, mem_ready low for 3 cycles in MEMRD -> MemRead=1, IorD=1 held 4 cycles. Then MEMWB with RegWrite=1, MemtoReg=1. Total 8 cycles.
- FETCH wait: mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 during the wait, both 1 only in the mem_ready cycle. sw: MemWrite pulses only in MEMWR; total 4 cycles.
- Branch/jump: beq (000100) -> BEQ with ALUOp=01, PCWriteCond=1, PCSource=01. j (000010) -> PCWrite=1, PCSource=10. JR (000000, funct 001000) -> state 12, PCSource=11, no RegWrite.
- Illegal: opcode=111111 -> DECODE then FETCH, illegal_op=1 for exactly 1 cycle. No write strobes asserted.
- Reset mid-op: assert rst_n=0 in MEMWR while mem_ready=0 -> MemWrite drops immediately (asynchronously). After release, FETCH with no RegWrite/MemWrite until a new instruction reaches its write state.
